branch_target_predictor: RTL

- Parametrised successor to the ID-stage branch-destination adder.
- Computes the branch destination in ID, as before.
- Adds a direct-mapped branch target buffer (BTB) with saturating counters, so IF_PC_Mux can redirect fetch in IF.
- Flags mispredictions from ID, so IF/ID can be flushed and the PC corrected.

---
 rtl/branch_target_predictor.sv | 132 +++++++++++++
 1 files changed

// File: rtl/branch_target_predictor.sv
// ID-stage branch destination adder plus a direct-mapped BTB with saturating
// direction counters; predicts in IF and flags mispredictions in ID.
module branch_target_predictor #(
   parameter int ADDR_WIDTH = 32,
   parameter int ENTRIES    = 16,
   parameter int CTR_BITS   = 2
) (
   input  logic                  Clk,
   input  logic                  Reset_n,
   input  logic [ADDR_WIDTH-1:0] PC_IF,
   output logic                  Predict_Taken_IF,
   output logic [ADDR_WIDTH-1:0] Predicted_Target_IF,
   input  logic                  Stall_ID,
   input  logic                  Flush_ID,
   input  logic                  Resolve_Valid_ID,
   input  logic [ADDR_WIDTH-1:0] PC_ID,
   input  logic [ADDR_WIDTH-1:0] PC_Plus_4_ID,
   input  logic [ADDR_WIDTH-1:0] Offset_Shift_Left_2_ID,
   input  logic                  Branch_Taken_ID,
   output logic [ADDR_WIDTH-1:0] Branch_Dest_ID,
   output logic                  Mispredict_ID,
   output logic [ADDR_WIDTH-1:0] Correct_PC_ID
);

   localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
   localparam int TAG_W = ADDR_WIDTH - IDX_W - 2;
   localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
   localparam logic [CTR_BITS-1:0] CTR_ZERO = '0;
   localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1) << (CTR_BITS - 1);

   logic [ENTRIES-1:0]    valid_q, valid_d;
   logic [TAG_W-1:0]      tag_q    [ENTRIES];
   logic [TAG_W-1:0]      tag_d    [ENTRIES];
   logic [ADDR_WIDTH-1:0] target_q [ENTRIES];
   logic [ADDR_WIDTH-1:0] target_d [ENTRIES];
   logic [CTR_BITS-1:0]   ctr_q    [ENTRIES];
   logic [CTR_BITS-1:0]   ctr_d    [ENTRIES];

   logic                  pred_taken_q, pred_taken_d;
   logic [ADDR_WIDTH-1:0] pred_target_q, pred_target_d;

   logic [IDX_W-1:0]      if_idx, id_idx;
   logic [TAG_W-1:0]      if_tag, id_tag;
   logic                  if_hit, id_hit;
   logic [CTR_BITS-1:0]   id_ctr;
   logic [ADDR_WIDTH-1:0] pc_if_plus4;
   logic                  upd_en;
   logic                  unused_pc_lsbs;

   assign unused_pc_lsbs = ^{PC_IF[1:0], PC_ID[1:0]};

   // Lookup reads pre-edge contents only; a same-cycle update is not bypassed.
   assign if_idx      = PC_IF[IDX_W+1:2];
   assign if_tag      = PC_IF[ADDR_WIDTH-1:IDX_W+2];
   assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
   assign pc_if_plus4 = PC_IF + ADDR_WIDTH'(4);

   assign Predict_Taken_IF    = if_hit && ctr_q[if_idx][CTR_BITS-1];
   assign Predicted_Target_IF = Predict_Taken_IF ? target_q[if_idx] : pc_if_plus4;

   assign Branch_Dest_ID = PC_Plus_4_ID + Offset_Shift_Left_2_ID;
   assign Correct_PC_ID  = Branch_Taken_ID ? Branch_Dest_ID : PC_Plus_4_ID;
   assign Mispredict_ID  = Resolve_Valid_ID &&
                           ((pred_taken_q != Branch_Taken_ID) ||
                            (Branch_Taken_ID && (pred_target_q != Branch_Dest_ID)));

   assign id_idx = PC_ID[IDX_W+1:2];
   assign id_tag = PC_ID[ADDR_WIDTH-1:IDX_W+2];
   assign id_hit = valid_q[id_idx] && (tag_q[id_idx] == id_tag);
   assign id_ctr = ctr_q[id_idx];
   assign upd_en = Resolve_Valid_ID && !Stall_ID;

   always_comb begin
      pred_taken_d  = pred_taken_q;
      pred_target_d = pred_target_q;
      if (Flush_ID) begin
         pred_taken_d  = 1'b0;
         pred_target_d = '0;
      end else if (!Stall_ID) begin
         pred_taken_d  = Predict_Taken_IF;
         pred_target_d = Predicted_Target_IF;
      end
   end

   always_comb begin
      valid_d = valid_q;
      for (int i = 0; i < ENTRIES; i++) begin
         tag_d[i]    = tag_q[i];
         target_d[i] = target_q[i];
         ctr_d[i]    = ctr_q[i];
      end
      if (upd_en) begin
         if (id_hit) begin
            if (Branch_Taken_ID) begin
               target_d[id_idx] = Branch_Dest_ID;
               if (id_ctr != CTR_MAX) ctr_d[id_idx] = id_ctr + CTR_BITS'(1);
            end else if (id_ctr != CTR_ZERO) begin
               ctr_d[id_idx] = id_ctr - CTR_BITS'(1);
            end
         end else if (Branch_Taken_ID) begin
            // Taken miss allocates (or evicts an alias) as weakly taken.
            valid_d[id_idx]  = 1'b1;
            tag_d[id_idx]    = id_tag;
            target_d[id_idx] = Branch_Dest_ID;
            ctr_d[id_idx]    = CTR_WEAK;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         valid_q       <= '0;
         pred_taken_q  <= 1'b0;
         pred_target_q <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= '0;
         end
      end else begin
         valid_q       <= valid_d;
         pred_taken_q  <= pred_taken_d;
         pred_target_q <= pred_target_d;
         for (int i = 0; i < ENTRIES; i++) begin
            tag_q[i]    <= tag_d[i];
            target_q[i] <= target_d[i];
            ctr_q[i]    <= ctr_d[i];
         end
      end
   end

endmodule
